// File: rtl/sprite_motion_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// sprite_motion_engine: per-tick X/frame/direction updater for N sprite
// records held in a single-port sprite RAM.          Revision: 1.0
// ---------------------------------------------------------------------------
module sprite_motion_engine #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int NUM_SPRITES = 4,
  parameter int BASE_ADDR   = 'h1000,
  parameter int STRIDE      = 4,
  parameter int TICK_COUNT  = 12500000,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 500,
  parameter int NUM_FRAMES  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  we_o,
  output logic                  busy_o,
  output logic                  pass_done_o,
  output logic                  overrun_o
);

  localparam int CNT_W = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int XW    = DATA_WIDTH + 1;
  localparam int B_ACT = 15;
  localparam int B_DIR = 14;
  localparam int B_BNC = 13;

  localparam logic [CNT_W-1:0]      TICK_LAST = CNT_W'(TICK_COUNT - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_SPRITES - 1);
  localparam logic [XW-1:0]         X_MIN_W   = XW'(X_MIN);
  localparam logic [XW-1:0]         X_MAX_W   = XW'(X_MAX);
  localparam logic [DATA_WIDTH-1:0] X_MIN_D   = DATA_WIDTH'(X_MIN);
  localparam logic [DATA_WIDTH-1:0] X_MAX_D   = DATA_WIDTH'(X_MAX);
  localparam logic [DATA_WIDTH-1:0] NF_D      = DATA_WIDTH'(NUM_FRAMES);
  localparam logic [DATA_WIDTH-1:0] F_TOP     = DATA_WIDTH'(NUM_FRAMES - 1);
  localparam logic [DATA_WIDTH-1:0] F_ONE     = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DIR_MASK  = DATA_WIDTH'(1) << B_DIR;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH_C = 3'd1,
    S_LOAD_C  = 3'd2,
    S_FETCH_X = 3'd3,
    S_SAVE_X  = 3'd4,
    S_FETCH_F = 3'd5,
    S_SAVE_F  = 3'd6,
    S_WRITE_C = 3'd7
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    pending_q, pending_d;
  logic                    overrun_q, overrun_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   ctrl_q, ctrl_d;
  logic                    hit_q, hit_d;
  logic [NUM_SPRITES-1:0]  up_q, up_d;

  logic                    w_tick, w_tick_acc, w_advance;
  logic [ADDR_WIDTH-1:0]   w_rec;
  logic [XW-1:0]           w_x, w_speed, w_sum, w_left_lim;
  logic [DATA_WIDTH-1:0]   w_x_new, w_f_new;
  logic                    w_x_hit, w_up_cur, w_up_new;

  assign w_tick     = (cnt_q == TICK_LAST);
  assign w_tick_acc = w_tick & enable_i;
  assign w_rec      = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(STRIDE);
  assign overrun_o  = overrun_q;

  // X arithmetic is one bit wider than the data so the bound tests cannot wrap
  assign w_x        = {1'b0, data_in_i};
  assign w_speed    = XW'(ctrl_q[3:0]);
  assign w_sum      = w_x + w_speed;
  assign w_left_lim = X_MIN_W + w_speed;

  always_comb begin
    w_x_hit = 1'b0;
    w_x_new = data_in_i;
    if (w_speed != '0) begin
      if (!ctrl_q[B_DIR]) begin
        if (w_sum >= X_MAX_W) begin
          w_x_hit = 1'b1;
          w_x_new = X_MAX_D;
        end else begin
          w_x_new = w_sum[DATA_WIDTH-1:0];
        end
      end else if (w_x < w_left_lim) begin
        w_x_hit = 1'b1;
        w_x_new = X_MIN_D;
      end else begin
        w_x_new = data_in_i - DATA_WIDTH'(ctrl_q[3:0]);
      end
    end
  end

  assign w_up_cur = up_q[idx_q];

  always_comb begin
    w_f_new  = F_ONE;
    w_up_new = w_up_cur;
    if (hit_q && !ctrl_q[B_BNC]) begin
      w_f_new = '0;
    end else if (data_in_i == '0 || data_in_i >= NF_D) begin
      w_f_new  = F_ONE;
      w_up_new = 1'b1;
    end else if (w_up_cur) begin
      w_f_new  = data_in_i + F_ONE;
      w_up_new = (w_f_new != F_TOP);
    end else begin
      w_f_new  = data_in_i - F_ONE;
      w_up_new = (w_f_new == F_ONE);
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ctrl_d      = ctrl_q;
    hit_d       = hit_q;
    up_d        = up_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    addr_o      = ADDR_WIDTH'(BASE_ADDR);
    data_out_o  = '0;
    we_o        = 1'b0;
    busy_o      = (state_q != S_IDLE);
    pass_done_o = 1'b0;
    w_advance   = 1'b0;

    if (busy_o && w_tick_acc) begin
      pending_d = 1'b1;
      if (pending_q) overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (w_tick_acc) state_d = S_FETCH_C;
      end
      S_FETCH_C: begin
        addr_o  = w_rec + ADDR_WIDTH'(3);
        state_d = S_LOAD_C;
      end
      S_LOAD_C: begin
        addr_o = w_rec + ADDR_WIDTH'(3);
        ctrl_d = data_in_i;
        hit_d  = 1'b0;
        if (data_in_i[B_ACT]) state_d = S_FETCH_X;
        else                  w_advance = 1'b1;
      end
      S_FETCH_X: begin
        addr_o  = w_rec;
        state_d = S_SAVE_X;
      end
      S_SAVE_X: begin
        addr_o     = w_rec;
        we_o       = 1'b1;
        data_out_o = w_x_new;
        hit_d      = w_x_hit;
        state_d    = S_FETCH_F;
      end
      S_FETCH_F: begin
        addr_o  = w_rec + ADDR_WIDTH'(2);
        state_d = S_SAVE_F;
      end
      S_SAVE_F: begin
        addr_o      = w_rec + ADDR_WIDTH'(2);
        we_o        = 1'b1;
        data_out_o  = w_f_new;
        up_d[idx_q] = w_up_new;
        if (hit_q && ctrl_q[B_BNC]) state_d = S_WRITE_C;
        else                        w_advance = 1'b1;
      end
      S_WRITE_C: begin
        addr_o     = w_rec + ADDR_WIDTH'(3);
        we_o       = 1'b1;
        data_out_o = ctrl_q ^ DIR_MASK;
        w_advance  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // A tick landing on the final cycle chains straight into the next pass
    if (w_advance) begin
      if (idx_q == IDX_LAST) begin
        pass_done_o = 1'b1;
        idx_d       = '0;
        if (pending_q || w_tick_acc) begin
          state_d   = S_FETCH_C;
          pending_d = pending_q && w_tick_acc;
        end else begin
          state_d   = S_IDLE;
        end
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = S_FETCH_C;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      idx_q     <= '0;
      ctrl_q    <= '0;
      hit_q     <= 1'b0;
      up_q      <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= w_tick ? '0 : cnt_q + CNT_W'(1);
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      idx_q     <= idx_d;
      ctrl_q    <= ctrl_d;
      hit_q     <= hit_d;
      up_q      <= up_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sprite_motion_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sprite_motion_engine: scoreboard bench with RAM model and reference
// model for sprite_motion_engine.                     Revision: 1.0
// ---------------------------------------------------------------------------
module tb_sprite_motion_engine;

  localparam int NS   = 4;
  localparam int TC   = 5;
  localparam int XMIN = 0;
  localparam int XMAX = 500;
  localparam int NF   = 4;
  localparam int BASE = 'h1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] data_in;
  logic [15:0] addr, data_out;
  logic        we, busy, pass_done, overrun;

  logic        h_we = 1'b0;
  logic [5:0]  h_idx = '0;
  logic [15:0] h_data = '0;

  logic [15:0] ram  [0:63];
  logic [15:0] smem [0:63];
  bit          up   [0:NS-1];

  logic [31:0] exp_q[$];
  int          len_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  sprite_motion_engine #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .NUM_SPRITES(NS), .BASE_ADDR(BASE),
    .STRIDE(4), .TICK_COUNT(TC), .X_MIN(XMIN), .X_MAX(XMAX), .NUM_FRAMES(NF)
  ) u_dut (
    .clk(clk), .reset(reset), .enable_i(enable), .data_in_i(data_in),
    .addr_o(addr), .data_out_o(data_out), .we_o(we), .busy_o(busy),
    .pass_done_o(pass_done), .overrun_o(overrun)
  );

  // Single-port synchronous RAM; the host port is used only while the DUT idles
  always @(posedge clk) begin
    if (h_we) ram[h_idx] <= h_data;
    else if (we && addr[15:6] == 10'h040) ram[addr[5:0]] <= data_out;
    data_in <= (addr[15:6] == 10'h040) ? ram[addr[5:0]] : 16'hDEAD;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic wr(input int idx, input logic [15:0] v);
    h_we = 1'b1; h_idx = 6'(idx); h_data = v;
    smem[idx] = v;
    @(negedge clk);
    h_we = 1'b0;
  endtask

  task automatic set_rec(input int s, input int x, input int f, input logic [15:0] c);
    wr(s*4 + 0, 16'(x));
    wr(s*4 + 1, 16'(s));
    wr(s*4 + 2, 16'(f));
    wr(s*4 + 3, c);
  endtask

  task automatic push(input int idx, input logic [15:0] v);
    exp_q.push_back({16'(BASE + idx), v});
    smem[idx] = v;
  endtask

  // One full update pass over the shadow memory, queuing the writes it implies
  task automatic model_pass();
    int len, x, sp, nx;
    logic [15:0] c, f, nf;
    bit hit;
    len = 0;
    for (int s = 0; s < NS; s++) begin
      c = smem[s*4 + 3];
      if (!c[15]) begin
        len += 2;
        continue;
      end
      len += 6;
      x = int'(smem[s*4]); sp = int'(c[3:0]); hit = 0; nx = x;
      if (sp != 0) begin
        if (!c[14]) begin
          if (x + sp >= XMAX) begin hit = 1; nx = XMAX; end else nx = x + sp;
        end else begin
          if (x < XMIN + sp) begin hit = 1; nx = XMIN; end else nx = x - sp;
        end
      end
      push(s*4, 16'(nx));
      f = smem[s*4 + 2];
      if (hit && !c[13]) nf = 16'd0;
      else if (f == 0 || f >= NF) begin nf = 16'd1; up[s] = 1; end
      else if (up[s]) begin nf = f + 16'd1; if (nf == NF - 1) up[s] = 0; end
      else begin nf = f - 16'd1; if (nf == 1) up[s] = 1; end
      push(s*4 + 2, nf);
      if (hit && c[13]) begin
        len++;
        push(s*4 + 3, c ^ 16'h4000);
      end
    end
    len_q.push_back(len);
  endtask

  task automatic monitor();
    int cyc;
    logic [31:0] e;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cyc = 0;
      end else begin
        if (busy) cyc++;
        if (we) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", {addr, data_out}, 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {16'h0, addr}, {16'h0, e[31:16]});
            chk("wr_data", {16'h0, data_out}, {16'h0, e[15:0]});
          end
        end else begin
          chk("dout_idle", {16'h0, data_out}, 32'h0);
        end
        if (pass_done) begin
          if (len_q.size() == 0) chk("unexpected_pass_done", 32'(cyc), 32'h0);
          else chk("pass_len", 32'(cyc), 32'(len_q.pop_front()));
          cyc = 0;
        end
        if (!busy) cyc = 0;
      end
    end
  endtask

  task automatic run_pass(output int cycles);
    int n;
    model_pass();
    enable = 1'b1;
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    enable = 1'b0;
    chk("pass_start", {31'h0, busy}, 32'h1);
    cycles = 1;
    while (!pass_done && cycles < 200) begin @(negedge clk); cycles++; end
    chk("pass_done_seen", {31'h0, pass_done}, 32'h1);
    @(negedge clk);
    chk("idle_after_pass", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int cyc, n;
    int fseq[6];
    bit seen;
    logic [15:0] c;
    fseq = '{1, 2, 3, 2, 1, 2};
    for (int s = 0; s < NS; s++) up[s] = 1;
    fork monitor(); join_none

    repeat (3) @(negedge clk);
    chk("rst_we", {31'h0, we}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_pass_done", {31'h0, pass_done}, 32'h0);
    chk("rst_addr", {16'h0, addr}, 32'h1000);
    chk("rst_dout", {16'h0, data_out}, 32'h0);
    chk("rst_overrun", {31'h0, overrun}, 32'h0);
    reset = 1'b0;

    // Walk: X steps by 4, frames ping-pong 1,2,3,2,1,2
    set_rec(0, 100, 0, 16'h8004);
    for (int s = 1; s < NS; s++) set_rec(s, 50, 1, 16'h0004);
    for (int k = 0; k < 6; k++) begin
      run_pass(cyc);
      chk("A_len", 32'(cyc), 32'd12);
      chk("A_x", {16'h0, ram[0]}, 32'(100 + 4*(k+1)));
      chk("A_frame", {16'h0, ram[2]}, 32'(fseq[k]));
    end

    // Right edge without bounce parks the sprite
    set_rec(0, 498, 1, 16'h8004);
    run_pass(cyc);
    chk("B_x", {16'h0, ram[0]}, 32'd500);
    chk("B_frame", {16'h0, ram[2]}, 32'd0);
    run_pass(cyc);
    chk("B_x2", {16'h0, ram[0]}, 32'd500);
    chk("B_frame2", {16'h0, ram[2]}, 32'd0);
    chk("B_ctrl2", {16'h0, ram[3]}, 32'h8004);

    // Right edge with bounce
    set_rec(0, 498, 1, 16'hA004);
    run_pass(cyc);
    chk("C_len", 32'(cyc), 32'd13);
    chk("C_x", {16'h0, ram[0]}, 32'd500);
    chk("C_ctrl", {16'h0, ram[3]}, 32'hE004);
    run_pass(cyc);
    chk("C_x2", {16'h0, ram[0]}, 32'd496);

    // Left edge with bounce
    set_rec(0, 2, 2, 16'hE004);
    run_pass(cyc);
    chk("D_x", {16'h0, ram[0]}, 32'd0);
    chk("D_ctrl", {16'h0, ram[3]}, 32'hA004);

    // Mixed active/inactive records
    set_rec(0, 100, 1, 16'h8004);
    set_rec(1, 200, 1, 16'h0004);
    set_rec(2, 300, 1, 16'h8002);
    set_rec(3, 50, 2, 16'hC003);
    run_pass(cyc);
    chk("E_len", 32'(cyc), 32'd20);
    chk("E_s1_x", {16'h0, ram[4]}, 32'd200);
    chk("E_s1_f", {16'h0, ram[6]}, 32'd1);
    chk("E_s1_c", {16'h0, ram[7]}, 32'h0004);
    chk("E_s3_x", {16'h0, ram[12]}, 32'd47);

    // Randomised positions and control words
    for (int i = 0; i < 40; i++) begin
      for (int s = 0; s < NS; s++) begin
        c = 16'($urandom());
        c[15] = ($urandom_range(0, 3) != 0);
        wr(s*4, 16'($urandom_range(0, 600)));
        wr(s*4 + 3, c);
      end
      run_pass(cyc);
    end

    // Ticks ignored while disabled
    enable = 1'b0;
    seen = 0;
    repeat (30) begin @(negedge clk); if (busy) seen = 1; end
    chk("disabled_no_pass", {31'h0, seen}, 32'h0);

    // Ticks faster than a pass: chaining, sticky overrun, then reset mid-write
    set_rec(0, 100, 1, 16'h8004);
    set_rec(1, 200, 1, 16'h8004);
    set_rec(2, 300, 1, 16'h8004);
    set_rec(3, 492, 1, 16'hA004);
    model_pass();
    model_pass();
    enable = 1'b1;
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    chk("ovr_start", {31'h0, busy}, 32'h1);
    n = 0;
    while (!pass_done && n < 100) begin @(negedge clk); n++; end
    chk("ovr_pass1_done", {31'h0, pass_done}, 32'h1);
    @(negedge clk);
    chk("chain_busy", {31'h0, busy}, 32'h1);
    chk("overrun_set", {31'h0, overrun}, 32'h1);
    n = 0;
    while (!(we && addr == 16'h100F) && n < 60) begin @(negedge clk); n++; end
    chk("writec_seen", {15'h0, we, addr}, {15'h0, 1'b1, 16'h100F});
    chk("overrun_sticky", {31'h0, overrun}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_we", {31'h0, we}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_overrun", {31'h0, overrun}, 32'h0);
    chk("mid_rst_pass_done", {31'h0, pass_done}, 32'h0);
    enable = 1'b0;
    exp_q.delete();
    len_q.delete();
    for (int s = 0; s < NS; s++) up[s] = 1;
    @(negedge clk);
    reset = 1'b0;

    // Up flags restart counting upward after reset
    set_rec(0, 100, 2, 16'h8004);
    for (int s = 1; s < NS; s++) set_rec(s, 50, 1, 16'h0004);
    run_pass(cyc);
    chk("post_rst_len", 32'(cyc), 32'd12);
    chk("post_rst_frame", {16'h0, ram[2]}, 32'd3);
    chk("post_rst_x", {16'h0, ram[0]}, 32'd104);
    repeat (3) @(negedge clk);
    chk("exp_queue_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
